// File: rtl/vga_frame_transmitter.sv
// VGA raster timing generator and pixel output stage.
// Requests each active pixel from a source one tick ahead and emits it aligned with the sync and data-enable outputs.
module vga_frame_transmitter #(
  parameter int P_PIXEL_DEPTH    = 24,
  parameter int P_HACT           = 640,
  parameter int P_HFP            = 16,
  parameter int P_HSW            = 96,
  parameter int P_HBP            = 48,
  parameter int P_VACT           = 480,
  parameter int P_VFP            = 10,
  parameter int P_VSH            = 2,
  parameter int P_VBP            = 33,
  parameter bit P_HSYNC_POLARITY = 1'b0,
  parameter bit P_VSYNC_POLARITY = 1'b0,
  parameter int P_CLK_DIV        = 1,
  parameter int P_COLUMN_BITS    = $clog2(P_HACT + P_HFP + P_HSW + P_HBP),
  parameter int P_ROW_BITS       = $clog2(P_VACT + P_VFP + P_VSH + P_VBP)
) (
  input  logic                     I_CLK,
  input  logic                     I_RESET,
  input  logic                     I_ENABLE,
  input  logic [P_PIXEL_DEPTH-1:0] I_PIXEL,
  output logic                     O_REQUEST,
  output logic [P_COLUMN_BITS-1:0] O_REQUEST_COLUMN,
  output logic [P_ROW_BITS-1:0]    O_REQUEST_ROW,
  output logic [P_PIXEL_DEPTH-1:0] O_PIXEL,
  output logic                     O_HSYNC,
  output logic                     O_VSYNC,
  output logic                     O_DATA_ENABLE,
  output logic                     O_PIXEL_STROBE,
  output logic                     O_FRAME_START
);

  // state    | meaning
  // ST_IDLE  | stopped; counters, pipeline and outputs held at reset values
  // ST_RUN   | raster counters advance on every pixel tick

  localparam int HTOTAL   = P_HACT + P_HFP + P_HSW + P_HBP;
  localparam int VTOTAL   = P_VACT + P_VFP + P_VSH + P_VBP;
  localparam int DIV_BITS = (P_CLK_DIV > 1) ? $clog2(P_CLK_DIV) : 1;

  localparam logic [DIV_BITS-1:0]      DIV_LAST     = DIV_BITS'(P_CLK_DIV - 1);
  localparam logic [P_COLUMN_BITS-1:0] H_LAST       = P_COLUMN_BITS'(HTOTAL - 1);
  localparam logic [P_COLUMN_BITS-1:0] H_ACT        = P_COLUMN_BITS'(P_HACT);
  localparam logic [P_COLUMN_BITS-1:0] H_SYNC_FIRST = P_COLUMN_BITS'(P_HACT + P_HFP);
  localparam logic [P_COLUMN_BITS-1:0] H_SYNC_LAST  = P_COLUMN_BITS'(P_HACT + P_HFP + P_HSW - 1);
  localparam logic [P_ROW_BITS-1:0]    V_LAST       = P_ROW_BITS'(VTOTAL - 1);
  localparam logic [P_ROW_BITS-1:0]    V_ACT        = P_ROW_BITS'(P_VACT);
  localparam logic [P_ROW_BITS-1:0]    V_SYNC_FIRST = P_ROW_BITS'(P_VACT + P_VFP);
  localparam logic [P_ROW_BITS-1:0]    V_SYNC_LAST  = P_ROW_BITS'(P_VACT + P_VFP + P_VSH - 1);
  localparam logic                     HS_ACT       = P_HSYNC_POLARITY;
  localparam logic                     VS_ACT       = P_VSYNC_POLARITY;

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t state_q, state_d;

  logic [DIV_BITS-1:0]      div_q, div_d;
  logic [P_COLUMN_BITS-1:0] h_q, h_d;
  logic [P_ROW_BITS-1:0]    v_q, v_d;
  logic                     de1_q, de1_d, hs1_q, hs1_d, vs1_q, vs1_d, first1_q, first1_d;
  logic [P_PIXEL_DEPTH-1:0] pix_q, pix_d;
  logic                     de_q, de_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d, stb_q, stb_d;

  logic tick, run_go, de0, hs0, vs0, req;

  assign tick   = (state_q == ST_RUN) && (div_q == DIV_LAST);
  assign run_go = (state_q == ST_RUN) && I_ENABLE;
  assign de0    = (h_q < H_ACT) && (v_q < V_ACT);
  assign hs0    = (h_q >= H_SYNC_FIRST) && (h_q <= H_SYNC_LAST);
  assign vs0    = (v_q >= V_SYNC_FIRST) && (v_q <= V_SYNC_LAST);
  assign req    = tick && de0;

  always_ff @(posedge I_CLK) begin
    if (I_RESET) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (I_ENABLE)  state_d = ST_RUN;
      ST_RUN:  if (!I_ENABLE) state_d = ST_IDLE;
    endcase
  end

  // Sync/DE flags are kept as "active" booleans; polarity is applied only at the pins.
  always_comb begin
    div_d    = div_q;
    h_d      = h_q;
    v_d      = v_q;
    de1_d    = de1_q;
    hs1_d    = hs1_q;
    vs1_d    = vs1_q;
    first1_d = first1_q;
    pix_d    = pix_q;
    de_d     = de_q;
    hs_d     = hs_q;
    vs_d     = vs_q;
    fs_d     = fs_q;
    stb_d    = 1'b0;
    if (!run_go) begin
      div_d    = '0;
      h_d      = '0;
      v_d      = '0;
      de1_d    = 1'b0;
      hs1_d    = 1'b0;
      vs1_d    = 1'b0;
      first1_d = 1'b0;
      pix_d    = '0;
      de_d     = 1'b0;
      hs_d     = 1'b0;
      vs_d     = 1'b0;
      fs_d     = 1'b0;
    end else if (tick) begin
      div_d = '0;
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
      de1_d    = de0;
      hs1_d    = hs0;
      vs1_d    = vs0;
      first1_d = (h_q == '0) && (v_q == '0);
      pix_d    = de1_q ? I_PIXEL : '0;
      de_d     = de1_q;
      hs_d     = hs1_q;
      vs_d     = vs1_q;
      fs_d     = first1_q;
      stb_d    = 1'b1;
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      div_q    <= '0;
      h_q      <= '0;
      v_q      <= '0;
      de1_q    <= 1'b0;
      hs1_q    <= 1'b0;
      vs1_q    <= 1'b0;
      first1_q <= 1'b0;
      pix_q    <= '0;
      de_q     <= 1'b0;
      hs_q     <= 1'b0;
      vs_q     <= 1'b0;
      fs_q     <= 1'b0;
      stb_q    <= 1'b0;
    end else begin
      div_q    <= div_d;
      h_q      <= h_d;
      v_q      <= v_d;
      de1_q    <= de1_d;
      hs1_q    <= hs1_d;
      vs1_q    <= vs1_d;
      first1_q <= first1_d;
      pix_q    <= pix_d;
      de_q     <= de_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      fs_q     <= fs_d;
      stb_q    <= stb_d;
    end
  end

  always_comb begin
    O_REQUEST        = req;
    O_REQUEST_COLUMN = req ? h_q : '0;
    O_REQUEST_ROW    = req ? v_q : '0;
    O_PIXEL          = pix_q;
    O_HSYNC          = hs_q ? HS_ACT : ~HS_ACT;
    O_VSYNC          = vs_q ? VS_ACT : ~VS_ACT;
    O_DATA_ENABLE    = de_q;
    O_PIXEL_STROBE   = stb_q;
    O_FRAME_START    = fs_q;
  end

endmodule

// File: tb/tb_vga_frame_transmitter.sv
// Bench for vga_frame_transmitter: two instances (divide-by-1 and divide-by-3) share run/stop/reset stimulus.
// Every cycle both are compared against a raster model computed from tick counts since the last start.
module tb_vga_frame_transmitter;

  localparam int HA = 4, HF = 1, HS = 1, HB = 1;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int PW = 24;

  typedef logic [35:0] obs_t;

  logic clk;
  logic rst, en;
  logic [PW-1:0] pin1, pin3;
  logic req1, req3;
  logic [2:0] col1, row1, col3, row3;
  logic [PW-1:0] pix1, pix3;
  logic hs1, vs1, de1, stb1, fs1;
  logic hs3, vs3, de3, stb3, fs3;

  logic [PW-1:0] mem [0:VA-1][0:HA-1];

  bit run;
  int r;
  int cyc;
  int pass_cnt, total_cnt;
  bit found;
  int len, sel, n_extra;

  vga_frame_transmitter #(
    .P_PIXEL_DEPTH(PW), .P_HACT(HA), .P_HFP(HF), .P_HSW(HS), .P_HBP(HB),
    .P_VACT(VA), .P_VFP(VF), .P_VSH(VS), .P_VBP(VB), .P_CLK_DIV(1)
  ) dut1 (
    .I_CLK(clk), .I_RESET(rst), .I_ENABLE(en), .I_PIXEL(pin1),
    .O_REQUEST(req1), .O_REQUEST_COLUMN(col1), .O_REQUEST_ROW(row1),
    .O_PIXEL(pix1), .O_HSYNC(hs1), .O_VSYNC(vs1), .O_DATA_ENABLE(de1),
    .O_PIXEL_STROBE(stb1), .O_FRAME_START(fs1)
  );

  vga_frame_transmitter #(
    .P_PIXEL_DEPTH(PW), .P_HACT(HA), .P_HFP(HF), .P_HSW(HS), .P_HBP(HB),
    .P_VACT(VA), .P_VFP(VF), .P_VSH(VS), .P_VBP(VB), .P_CLK_DIV(3)
  ) dut3 (
    .I_CLK(clk), .I_RESET(rst), .I_ENABLE(en), .I_PIXEL(pin3),
    .O_REQUEST(req3), .O_REQUEST_COLUMN(col3), .O_REQUEST_ROW(row3),
    .O_PIXEL(pix3), .O_HSYNC(hs3), .O_VSYNC(vs3), .O_DATA_ENABLE(de3),
    .O_PIXEL_STROBE(stb3), .O_FRAME_START(fs3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs in the current cycle: r is the index of this RUN cycle since the last start.
  function automatic obs_t model(input int div);
    logic req, hs, vs, de, stb, fs;
    logic [2:0] col, row;
    logic [PW-1:0] pix;
    int n, m, px, py;
    req = 1'b0; col = '0; row = '0; pix = '0;
    hs = 1'b1; vs = 1'b1; de = 1'b0; stb = 1'b0; fs = 1'b0;
    if (run) begin
      n  = r / div;
      px = n % HT;
      py = (n / HT) % VT;
      if ((r % div) == div - 1 && px < HA && py < VA) begin
        req = 1'b1; col = 3'(px); row = 3'(py);
      end
      stb = (r > 0) && (r % div == 0);
      m = r / div;
      if (m >= 2) begin
        px = (m - 2) % HT;
        py = ((m - 2) / HT) % VT;
        de = (px < HA) && (py < VA);
        hs = !(px >= HA + HF && px <= HA + HF + HS - 1);
        vs = !(py >= VA + VF && py <= VA + VF + VS - 1);
        fs = (px == 0) && (py == 0);
        pix = de ? mem[py][px] : '0;
      end
    end
    return {req, col, row, pix, hs, vs, de, stb, fs};
  endfunction

  task automatic check_one(input string tag, input int div, input obs_t got);
    obs_t exp;
    exp = model(div);
    total_cnt++;
    assert (got === exp) pass_cnt++;
    else $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
  endtask

  // Called at a negedge: check this cycle, apply inputs, advance the model across the edge.
  task automatic step(input bit e, input bit rs);
    check_one("div1", 1, {req1, col1, row1, pix1, hs1, vs1, de1, stb1, fs1});
    check_one("div3", 3, {req3, col3, row3, pix3, hs3, vs3, de3, stb3, fs3});
    en  = e;
    rst = rs;
    @(posedge clk);
    if (rs)               begin run = 1'b0; r = 0; end
    else if (run && !e)   begin run = 1'b0; r = 0; end
    else if (!run && e)   begin run = 1'b1; r = 0; end
    else if (run)         r++;
    cyc++;
    @(negedge clk);
  endtask

  // Pixel sources: junk on the bus except in the last cycle before the sampling tick.
  initial begin
    int cnt;
    logic [PW-1:0] val;
    cnt = 0; val = '0; pin1 = '0;
    forever begin
      @(negedge clk);
      if (cnt > 0) begin
        cnt--;
        pin1 = (cnt == 0) ? val : PW'($urandom);
      end else begin
        pin1 = PW'($urandom);
      end
      if (req1 === 1'b1) begin
        cnt = 1;
        val = mem[int'(row1) % VA][int'(col1) % HA];
      end
    end
  end

  initial begin
    int cnt;
    logic [PW-1:0] val;
    cnt = 0; val = '0; pin3 = '0;
    forever begin
      @(negedge clk);
      if (cnt > 0) begin
        cnt--;
        pin3 = (cnt == 0) ? val : PW'($urandom);
      end else begin
        pin3 = PW'($urandom);
      end
      if (req3 === 1'b1) begin
        cnt = 3;
        val = mem[int'(row3) % VA][int'(col3) % HA];
      end
    end
  end

  initial begin
    pass_cnt = 0; total_cnt = 0; cyc = 0;
    run = 1'b0; r = 0;
    rst = 1'b1; en = 1'b0;
    for (int y = 0; y < VA; y++)
      for (int x = 0; x < HA; x++)
        mem[y][x] = PW'($urandom);
    @(negedge clk);

    // reset, then held idle
    step(0, 1);
    step(0, 1);
    for (int i = 0; i < 10; i++) step(0, 0);

    // free run: several div1 frames, more than two div3 frames
    for (int i = 0; i < 300; i++) step(1, 0);
    step(0, 0);
    step(0, 0);

    // stop exactly on the request for (2,1), then restart
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      if (req1 === 1'b1 && col1 == 3'd2 && row1 == 3'd1) found = 1'b1;
      else step(1, 0);
    end
    total_cnt++;
    assert (found) pass_cnt++;
    else $error("FAIL find_req21 got=%0d exp=1", found);
    step(0, 0);
    step(0, 0);
    for (int i = 0; i < 20; i++) step(1, 0);

    // reset mid-line with enable held high
    step(1, 1);
    for (int i = 0; i < 60; i++) step(1, 0);

    // random run lengths interleaved with stops and resets
    for (int s = 0; s < 25; s++) begin
      len = $urandom_range(1, 160);
      for (int i = 0; i < len; i++) step(1, 0);
      sel = $urandom_range(0, 2);
      n_extra = $urandom_range(1, 4);
      case (sel)
        0: for (int i = 0; i < n_extra; i++) step(0, 0);
        1: for (int i = 0; i < n_extra; i++) step(1, 1);
        default: begin step(0, 1); step(0, 0); end
      endcase
    end
    step(0, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
